// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types for the pipeline control slice
//
// Contents:
//   regbits_t    : register-index type (5-bit register file)
//   ctrl_state_t : pipeline_ctrl sequencer states
package cpu_types_pkg;

    localparam int REGBITS = 5;

    typedef logic [REGBITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// rtl/pipeline_ctrl_hazard_detect.sv - combinational load-use hazard compare
//
// Ports:
//   ex_dREN   in  ID/EX holds a load
//   ex_regDst in  ID/EX destination register
//   id_rs     in  IF/ID source register rs
//   id_rt     in  IF/ID source register rt
//   lduse     out load in EX feeds a source of the instruction in ID
module hazard_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_regDst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             lduse
);

    // Register 0 is hardwired zero, so a load targeting it never creates a dependency.
    assign lduse = ex_dREN
                 & (ex_regDst != '0)
                 & ((ex_regDst == id_rs) | (ex_regDst == id_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Optional feature macro: STALL_CNT_EN (adds stall_ld/stall_mem counters).
//
// Ports:
//   CLK, RST              clock, asynchronous active-high reset
//   ihit, dhit            instruction / data memory completed this cycle
//   mem_dREN, mem_dWEN    EX/MEM holds a load / store
//   mem_halt              EX/MEM holds halt
//   ex_dREN, ex_regDst    ID/EX load flag and destination register
//   id_rs, id_rt          IF/ID source registers
//   redirect              taken branch/jump resolved in MEM
//   pcen, ifen, exen, memen, wben   stage register enables
//   id_flush, ex_flush, mem_flush   stage registers load a bubble
//   redirect_sel          PC mux takes the branch target
//   halt                  sticky halt
//   stall_ld, stall_mem   saturating stall counters (STALL_CNT_EN only)
module pipeline_ctrl
    import cpu_types_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int REG_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_regDst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             redirect,
    output logic             pcen,
    output logic             ifen,
    output logic             exen,
    output logic             memen,
    output logic             wben,
    output logic             id_flush,
    output logic             ex_flush,
    output logic             mem_flush,
    output logic             redirect_sel,
    output logic             halt
`ifdef STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_ld,
    output logic [CNT_W-1:0] stall_mem
`endif
);

    ctrl_state_t state, state_n;
    logic        redir_pend, redir_pend_n;

    logic lduse;
    logic mem_busy;
    logic frozen;
    logic take_redirect;

    logic pcen_c, ifen_c, exen_c, memen_c, wben_c;
    logic id_flush_c, ex_flush_c, mem_flush_c, redirect_sel_c, halt_c;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ex_dREN   (ex_dREN),
        .ex_regDst (ex_regDst),
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .lduse     (lduse)
    );

    assign mem_busy = (mem_dREN | mem_dWEN) & ~dhit;

    // Once in DWAIT the access is known outstanding; only dhit releases the freeze.
    assign frozen        = (state == DWAIT) ? ~dhit : mem_busy;
    assign take_redirect = redirect | redir_pend;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            redir_pend <= 1'b0;
        end else begin
            state      <= state_n;
            redir_pend <= redir_pend_n;
        end
    end

    always_comb begin
        state_n        = state;
        redir_pend_n   = redir_pend;
        pcen_c         = 1'b0;
        ifen_c         = 1'b0;
        exen_c         = 1'b0;
        memen_c        = 1'b0;
        wben_c         = 1'b0;
        id_flush_c     = 1'b0;
        ex_flush_c     = 1'b0;
        mem_flush_c    = 1'b0;
        redirect_sel_c = 1'b0;
        halt_c         = 1'b0;

        case (state)
            HALTED: begin
                halt_c = 1'b1;
            end
            default: begin
                if (frozen) begin
                    // Whole pipe holds; remember any redirect so it is not lost.
                    state_n      = DWAIT;
                    redir_pend_n = redir_pend | redirect;
                end else begin
                    state_n = mem_halt ? HALTED : RUN;
                    exen_c  = 1'b1;
                    memen_c = 1'b1;
                    wben_c  = 1'b1;
                    if (take_redirect) begin
                        // Wrong-path instructions in IF/ID, ID/EX, EX/MEM are squashed.
                        pcen_c         = 1'b1;
                        ifen_c         = 1'b1;
                        redirect_sel_c = 1'b1;
                        id_flush_c     = 1'b1;
                        ex_flush_c     = 1'b1;
                        mem_flush_c    = 1'b1;
                        redir_pend_n   = 1'b0;
                    end else if (lduse) begin
                        // Hold PC and IF/ID; the bubble in ID/EX clears the hazard next cycle.
                        ex_flush_c = 1'b1;
                    end else if (!ihit) begin
                        // Fetch not back yet: keep PC, drain downstream behind a bubble.
                        ifen_c     = 1'b1;
                        id_flush_c = 1'b1;
                    end else begin
                        pcen_c = 1'b1;
                        ifen_c = 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs are forced low while reset is asserted, independent of inputs.
    assign pcen         = pcen_c & ~RST;
    assign ifen         = ifen_c & ~RST;
    assign exen         = exen_c & ~RST;
    assign memen        = memen_c & ~RST;
    assign wben         = wben_c & ~RST;
    assign id_flush     = id_flush_c & ~RST;
    assign ex_flush     = ex_flush_c & ~RST;
    assign mem_flush    = mem_flush_c & ~RST;
    assign redirect_sel = redirect_sel_c & ~RST;
    assign halt         = halt_c & ~RST;

`ifdef STALL_CNT_EN
    logic             ld_stall;
    logic             mem_stall;
    logic [CNT_W-1:0] ld_cnt;
    logic [CNT_W-1:0] mem_cnt;

    // Both qualifiers exclude HALTED, which is what freezes the counters there.
    assign ld_stall  = (state != HALTED) & ~frozen & ~take_redirect & lduse;
    assign mem_stall = (state != HALTED) & frozen;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ld_cnt  <= '0;
            mem_cnt <= '0;
        end else begin
            if (ld_stall && (ld_cnt != '1)) begin
                ld_cnt <= ld_cnt + 1'b1;
            end
            if (mem_stall && (mem_cnt != '1)) begin
                mem_cnt <= mem_cnt + 1'b1;
            end
        end
    end

    assign stall_ld  = ld_cnt;
    assign stall_mem = mem_cnt;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage pipeline; drives every stage-register enable (pcen, ifen/exen/memen/wben) and flush, including execute's exen and flush.
- Resolves instruction-fetch wait, data-memory wait, load-use hazards, taken branches/jumps and halt.
- Registered FSM holds memory-wait and halt state, plus a pending-redirect flag for redirects that arrive while the pipe is frozen.

Parameters:
- CNT_W, 32, width of optional stall counters.
- REG_W, 5, register-index width.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous reset, active-high
- ihit  in  1  instruction memory returned this cycle
- dhit  in  1  data memory completed this cycle
- mem_dREN  in  1  EX/MEM holds a load
- mem_dWEN  in  1  EX/MEM holds a store
- mem_halt  in  1  EX/MEM holds halt
- ex_dREN  in  1  ID/EX holds a load
- ex_regDst  in  REG_W  ID/EX destination register
- id_rs  in  REG_W  IF/ID source register rs
- id_rt  in  REG_W  IF/ID source register rt
- redirect  in  1  taken branch/jump resolved in MEM
- pcen  out  1  PC update enable
- ifen  out  1  IF/ID enable
- exen  out  1  ID/EX enable
- memen  out  1  EX/MEM enable
- wben  out  1  MEM/WB enable
- id_flush  out  1  IF/ID loads bubble
- ex_flush  out  1  ID/EX loads bubble
- mem_flush  out  1  EX/MEM loads bubble
- redirect_sel  out  1  PC mux takes branch target
- halt  out  1  sticky halt
- stall_ld  out  CNT_W  load-use stall count (STALL_CNT_EN only)
- stall_mem  out  CNT_W  memory-wait stall count (STALL_CNT_EN only)

Behaviour:
- States:
  - RUN=0.
  - DWAIT=1: EX/MEM access outstanding.
  - HALTED=2.
- All outputs come from state plus current inputs (combinational). Only the state, redir_pend and the counters are registered.
- Reset (async, RST=1): state=RUN, redir_pend=0, counters=0. Every enable, flush and redirect_sel output reads 0 in reset; halt=0.
- mem_busy = (mem_dREN|mem_dWEN) & ~dhit.
- RUN with mem_busy: all enables=0, no flushes. Next state=DWAIT. Capture redir_pend |= redirect.
- DWAIT: freeze persists until dhit, then behave as RUN on that cycle.
- Advance cycle (not frozen):
  - memen=wben=exen=1.
  - Taken redirect (redirect|redir_pend):
    - pcen=1, redirect_sel=1, id_flush=ex_flush=mem_flush=1, redir_pend cleared.
    - Overrides load-use and ihit stall.
  - Else load-use (ex_dREN & ex_regDst!=0 & (ex_regDst==id_rs | ex_regDst==id_rt)): pcen=0, ifen=0, ex_flush=1. Exactly one bubble per hazard.
  - Else ~ihit: pcen=0, ifen=1, id_flush=1 (bubble into IF/ID, downstream drains).
  - Else: pcen=ifen=1.
- A flush overrides its own stage's enable; the flushed register still clocks the bubble.
- Halt: mem_halt on an advance cycle sets state=HALTED. HALTED forces all enables/flushes=0 and halt=1 until reset; no further transitions.
- Reset mid-DWAIT: pending access is abandoned, redir_pend lost.
- ihit and dhit in the same cycle both count as hits; dhit has priority for the freeze decision.

Optional Feature:
- STALL_CNT_EN defined:
  - stall_ld increments on every load-use stall cycle.
  - stall_mem increments on every mem_busy cycle.
  - Both saturate at all-ones and freeze in HALTED.
- Undefined: counters and the stall_ld/stall_mem ports are absent; no logic generated.

Decomposition:
- cpu_types_pkg: ctrl_state_t enum (RUN, DWAIT, HALTED); regbits_t is used for register indices.
- Sub-module hazard_detect: combinational load-use compare (ex_dREN, ex_regDst, id_rs, id_rt -> lduse). Instantiated once.

Test Plan:
1. Reset release, ihit=1, no hazards -> pcen=ifen=exen=memen=wben=1, all flushes 0, halt=0.
2. ex_dREN=1, ex_regDst=8, id_rt=8 -> one cycle pcen=0, ifen=0, ex_flush=1. Then ex_dREN=0 -> normal advance. With ex_regDst=0 -> no stall.
3. mem_dREN=1, dhit=0 for 3 cycles, redirect=1 in cycle 2 -> all enables 0 for 3 cycles (state DWAIT). On the dhit cycle: redirect_sel=1 and id/ex/mem_flush=1.
4. redirect=1 together with load-use and ihit=0 -> redirect wins: pcen=1, redirect_sel=1, three flushes=1.
5. mem_halt=1 on an advance cycle -> next cycle halt=1 and all enables 0. halt stays 1 for 10+ cycles; RST=1 clears it asynchronously.
6. STALL_CNT_EN: 2 load-use cycles plus 5 mem-wait cycles -> stall_ld=2, stall_mem=5. Preload near all-ones -> counters saturate.
